bus_load_regfile: RTL and testbench

- Destination end of the datapath bus. Captures the single 32-bit bus value into the general registers R0–R15 and the HI/LO registers on per-register load strobes.
- Presents every stored value back as a bus-source input, named to match the bus multiplexer's inputs.
- Provides R0 zero-gating for base-address arithmetic.
- Tracks the last loaded destination and flags illegal multi-destination loads for the control unit and the testbench.

---
 rtl/bus_load_regfile.sv | 124 ++++++++++++
 tb/tb_bus_load_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_load_regfile.sv
// Destination end of the datapath bus: R0-R15, HI and LO capture the bus value
// on their load strobes and are presented back as bus-multiplexer source inputs.
// Also records the last loaded destination and a sticky multi-destination error.
module bus_load_regfile #(
  parameter int WIDTH    = 32,
  parameter bit R0_GATED = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic [15:0]      Rin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             BAout,
  output logic [WIDTH-1:0] BusMuxInR0,
  output logic [WIDTH-1:0] BusMuxInR1,
  output logic [WIDTH-1:0] BusMuxInR2,
  output logic [WIDTH-1:0] BusMuxInR3,
  output logic [WIDTH-1:0] BusMuxInR4,
  output logic [WIDTH-1:0] BusMuxInR5,
  output logic [WIDTH-1:0] BusMuxInR6,
  output logic [WIDTH-1:0] BusMuxInR7,
  output logic [WIDTH-1:0] BusMuxInR8,
  output logic [WIDTH-1:0] BusMuxInR9,
  output logic [WIDTH-1:0] BusMuxInR10,
  output logic [WIDTH-1:0] BusMuxInR11,
  output logic [WIDTH-1:0] BusMuxInR12,
  output logic [WIDTH-1:0] BusMuxInR13,
  output logic [WIDTH-1:0] BusMuxInR14,
  output logic [WIDTH-1:0] BusMuxInR15,
  output logic [WIDTH-1:0] BusMuxInHI,
  output logic [WIDTH-1:0] BusMuxInLO,
  output logic [4:0]       last_dst,
  output logic             last_valid,
  output logic             multi_load_err
);

  // Destination codes: 0-15 = Rk, 16 = HI, 17 = LO; bit index of strobes == code.
  logic [17:0]      strobes;
  logic [4:0]       n_strobe;
  logic [4:0]       low_code;

  logic [WIDTH-1:0] r_q [16];
  logic [WIDTH-1:0] r_d [16];
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [4:0]       last_dst_q, last_dst_d;
  logic             last_valid_q, last_valid_d;
  logic             multi_load_err_q, multi_load_err_d;

  assign strobes = {LOin, HIin, Rin};

  // Strobe decode: how many destinations fire and which has the lowest code.
  always_comb begin
    n_strobe = 5'd0;
    low_code = 5'd0;
    for (int i = 0; i < 18; i++) begin
      n_strobe = n_strobe + {4'd0, strobes[i]};
    end
    for (int i = 17; i >= 0; i--) begin
      if (strobes[i]) low_code = 5'(i);
    end
  end

  // Next-state: every strobed destination captures the bus verbatim, others hold.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      r_d[k] = Rin[k] ? BusMuxOut : r_q[k];
    end
    hi_d             = HIin ? BusMuxOut : hi_q;
    lo_d             = LOin ? BusMuxOut : lo_q;
    last_dst_d       = last_dst_q;
    last_valid_d     = last_valid_q;
    multi_load_err_d = multi_load_err_q | (n_strobe > 5'd1);
    if (|strobes) begin
      last_dst_d   = low_code;
      last_valid_d = 1'b1;
    end
  end

  // Storage and tracking registers; clear wipes everything asynchronously.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < 16; k++) r_q[k] <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      last_dst_q       <= 5'd0;
      last_valid_q     <= 1'b0;
      multi_load_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) r_q[k] <= r_d[k];
      hi_q             <= hi_d;
      lo_q             <= lo_d;
      last_dst_q       <= last_dst_d;
      last_valid_q     <= last_valid_d;
      multi_load_err_q <= multi_load_err_d;
    end
  end

  // R0 reads as zero for base-address arithmetic; the stored value is untouched.
  assign BusMuxInR0  = (R0_GATED && BAout) ? '0 : r_q[0];
  assign BusMuxInR1  = r_q[1];
  assign BusMuxInR2  = r_q[2];
  assign BusMuxInR3  = r_q[3];
  assign BusMuxInR4  = r_q[4];
  assign BusMuxInR5  = r_q[5];
  assign BusMuxInR6  = r_q[6];
  assign BusMuxInR7  = r_q[7];
  assign BusMuxInR8  = r_q[8];
  assign BusMuxInR9  = r_q[9];
  assign BusMuxInR10 = r_q[10];
  assign BusMuxInR11 = r_q[11];
  assign BusMuxInR12 = r_q[12];
  assign BusMuxInR13 = r_q[13];
  assign BusMuxInR14 = r_q[14];
  assign BusMuxInR15 = r_q[15];
  assign BusMuxInHI  = hi_q;
  assign BusMuxInLO  = lo_q;

  assign last_dst       = last_dst_q;
  assign last_valid     = last_valid_q;
  assign multi_load_err = multi_load_err_q;

endmodule

// File: tb/tb_bus_load_regfile.sv
// Scoreboard bench for bus_load_regfile: the stimulus process pushes expected
// output values into a queue; a monitor on the falling edge pops and compares.
module tb_bus_load_regfile;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic [15:0] Rin;
  logic        HIin, LOin, BAout;
  logic [31:0] outs [18];
  logic [4:0]  last_dst;
  logic        last_valid, multi_load_err;

  typedef struct {
    string       name;
    int          sel;   // 0-17 data outputs, 18 last_dst, 19 last_valid, 20 multi_load_err
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Hand-maintained expected contents of R0-R15, HI, LO and tracking outputs.
  logic [31:0] exp_r [18];
  logic [4:0]  exp_dst;
  logic        exp_valid, exp_multi;

  always #5 clock = ~clock;

  bus_load_regfile #(.WIDTH(32), .R0_GATED(1'b1)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .Rin(Rin),
    .HIin(HIin), .LOin(LOin), .BAout(BAout),
    .BusMuxInR0(outs[0]),   .BusMuxInR1(outs[1]),   .BusMuxInR2(outs[2]),
    .BusMuxInR3(outs[3]),   .BusMuxInR4(outs[4]),   .BusMuxInR5(outs[5]),
    .BusMuxInR6(outs[6]),   .BusMuxInR7(outs[7]),   .BusMuxInR8(outs[8]),
    .BusMuxInR9(outs[9]),   .BusMuxInR10(outs[10]), .BusMuxInR11(outs[11]),
    .BusMuxInR12(outs[12]), .BusMuxInR13(outs[13]), .BusMuxInR14(outs[14]),
    .BusMuxInR15(outs[15]), .BusMuxInHI(outs[16]),  .BusMuxInLO(outs[17]),
    .last_dst(last_dst), .last_valid(last_valid), .multi_load_err(multi_load_err)
  );

  // Strobes must be known whenever the block is out of reset.
  always @(posedge clock) begin
    if (!clear) assert (!$isunknown({Rin, HIin, LOin}))
      else $error("unknown strobe");
  end

  // Monitor: every queued expectation is compared against the live outputs.
  always @(negedge clock) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.sel)
        18:      act = {27'd0, last_dst};
        19:      act = {31'd0, last_valid};
        20:      act = {31'd0, multi_load_err};
        default: act = outs[c.sel];
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %08h required %08h", c.name, act, c.exp);
      end
    end
  end

  function automatic void push(string name, int sel, logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    sb.push_back(c);
  endfunction

  // Expect every data output plus tracking outputs for the current state.
  function automatic void push_all(string tag);
    for (int k = 0; k < 18; k++) begin
      push($sformatf("%s.%0s", tag, k == 16 ? "HI" : k == 17 ? "LO" : $sformatf("R%0d", k)),
           k, (k == 0 && BAout) ? 32'h0 : exp_r[k]);
    end
    push({tag, ".last_dst"}, 18, {27'd0, exp_dst});
    push({tag, ".last_valid"}, 19, {31'd0, exp_valid});
    push({tag, ".multi_load_err"}, 20, {31'd0, exp_multi});
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 18; k++) exp_r[k] = 32'h0;
    exp_dst = 5'd0; exp_valid = 1'b0; exp_multi = 1'b0;
  endfunction

  // Present one load for exactly one rising edge, then drop the strobes.
  task automatic load(input logic [15:0] rin, input logic hi, input logic lo,
                      input logic [31:0] bus);
    Rin = rin; HIin = hi; LOin = lo; BusMuxOut = bus;
    @(posedge clock); #1;
    Rin = 16'h0; HIin = 1'b0; LOin = 1'b0;
  endtask

  initial begin
    clear = 1'b1; BusMuxOut = 32'h0; Rin = 16'h0; HIin = 1'b0; LOin = 1'b0; BAout = 1'b0;
    clear_model();
    #1 push_all("rst");
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(posedge clock); #1;
    push_all("post_rst");

    // Single loads
    load(16'h0008, 1'b0, 1'b0, 32'hDEADBEEF);
    exp_r[3] = 32'hDEADBEEF; exp_dst = 5'd3; exp_valid = 1'b1;
    push_all("ld_r3");
    load(16'h0000, 1'b1, 1'b0, 32'h00000007);
    exp_r[16] = 32'h00000007; exp_dst = 5'd16;
    push_all("ld_hi");

    // R0 gating
    load(16'h0001, 1'b0, 1'b0, 32'hFFFFFFFF);
    exp_r[0] = 32'hFFFFFFFF; exp_dst = 5'd0;
    push_all("ld_r0");
    @(negedge clock); #1;
    BAout = 1'b1;
    push("gate_on.R0", 0, 32'h00000000);
    push("gate_on.R1", 1, 32'h00000000);
    push("gate_on.R3", 3, 32'hDEADBEEF);
    @(negedge clock); #1;
    BAout = 1'b0;
    push("gate_off.R0", 0, 32'hFFFFFFFF);

    // Hold: bus toggles with no strobes
    for (int i = 0; i < 10; i++) begin
      BusMuxOut = $urandom;
      @(posedge clock); #1;
      push_all($sformatf("hold%0d", i));
    end

    // Multi-destination load
    load(16'h0204, 1'b0, 1'b1, 32'h0000ABCD);
    exp_r[9] = 32'h0000ABCD; exp_r[2] = 32'h0000ABCD; exp_r[17] = 32'h0000ABCD;
    exp_dst = 5'd2; exp_multi = 1'b1;
    push_all("multi");
    load(16'h0010, 1'b0, 1'b0, 32'h00000055);
    exp_r[4] = 32'h00000055; exp_dst = 5'd4;
    push_all("after_multi");

    // Back-to-back loads into R7
    Rin = 16'h0080; BusMuxOut = 32'd1;
    @(posedge clock); #1;
    BusMuxOut = 32'd2; push("b2b1.R7", 7, 32'd1);
    @(posedge clock); #1;
    BusMuxOut = 32'd3; push("b2b2.R7", 7, 32'd2);
    @(posedge clock); #1;
    Rin = 16'h0; push("b2b3.R7", 7, 32'd3);
    push("b2b.last_dst", 18, 32'd7);
    exp_r[7] = 32'd3; exp_dst = 5'd7;

    // Mid-run clear, overriding a load presented in the same cycle
    load(16'h0020, 1'b0, 1'b0, 32'h12345678);
    exp_r[5] = 32'h12345678; exp_dst = 5'd5;
    push_all("ld_r5");
    @(negedge clock); #1;
    Rin = 16'h0040; BusMuxOut = 32'hCAFEF00D; clear = 1'b1;
    clear_model();
    #1 push_all("clr_now");
    @(posedge clock); #1;
    push_all("clr_hold");
    Rin = 16'h0;
    clear = 1'b0;
    @(posedge clock); #1;
    push_all("clr_rel");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
